// File: rtl/i2s_slave_rx_capture.sv
// I2S slave receive front end: oversamples the I2S pins in the WB_CLK domain,
// deserialises left/right words into stereo frames, buffers them and requests SDMA.
module i2s_slave_rx_capture #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int DMA_THRESH = 2
) (
    input  logic                          WB_CLK,
    input  logic                          WB_RST_n,
    input  logic                          I2S_CLK_i,
    input  logic                          I2S_WS_CLK_i,
    input  logic                          I2S_DIN_i,
    input  logic                          Enable_i,
    input  logic                          Intr_Clr_i,
    input  logic                          Rd_En_i,
    output logic [2*DATA_WIDTH-1:0]       Rd_Data_o,
    output logic                          Fifo_Empty_o,
    output logic [$clog2(FIFO_DEPTH):0]   Fifo_Level_o,
    output logic                          SDMA_Req_o,
    input  logic                          SDMA_Active_i,
    input  logic                          SDMA_Done_i,
    output logic                          DMA_Intr_o,
    output logic                          Overrun_Intr_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam int FRM_W = 2 * DATA_WIDTH;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SYNC = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    localparam logic [1:0] D_IDLE = 2'd0;
    localparam logic [1:0] D_REQ  = 2'd1;
    localparam logic [1:0] D_ACT  = 2'd2;

    logic [2:0]            bclk_sync_q;
    logic [1:0]            ws_sync_q;
    logic [1:0]            din_sync_q;
    logic                  bclk_rise;
    logic                  ws_s;
    logic                  din_s;

    logic [1:0]            cap_state_q, cap_state_d;
    logic                  ws_prev_q, ws_prev_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] left_hold_q, left_hold_d;
    logic                  left_valid_q, left_valid_d;
    logic [DATA_WIDTH-1:0] placed;
    logic                  push;
    logic [FRM_W-1:0]      push_word;

    logic [FRM_W-1:0]      mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]      level_q, level_d;
    logic                  overrun_q, overrun_d;
    logic                  flush;
    logic                  full;
    logic                  empty;
    logic                  do_push;
    logic                  do_pop;

    logic [1:0]            dma_state_q, dma_state_d;
    logic                  dma_intr_q, dma_intr_d;

    assign bclk_rise = bclk_sync_q[1] & ~bclk_sync_q[2];
    assign ws_s      = ws_sync_q[1];
    assign din_s     = din_sync_q[1];

    always_ff @(posedge WB_CLK or negedge WB_RST_n) begin
        if (!WB_RST_n) begin
            bclk_sync_q <= '0;
            ws_sync_q   <= '0;
            din_sync_q  <= '0;
        end else begin
            bclk_sync_q <= {bclk_sync_q[1:0], I2S_CLK_i};
            ws_sync_q   <= {ws_sync_q[0], I2S_WS_CLK_i};
            din_sync_q  <= {din_sync_q[0], I2S_DIN_i};
        end
    end

    // Bits land directly at their left-aligned position, so short words come out zero-padded.
    always_comb begin
        cap_state_d  = cap_state_q;
        ws_prev_d    = ws_prev_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        left_hold_d  = left_hold_q;
        left_valid_d = left_valid_q;
        push         = 1'b0;
        push_word    = '0;
        placed       = shift_q;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (bit_cnt_q == CNT_W'(DATA_WIDTH - 1 - i)) begin
                placed[i] = din_s;
            end
        end
        if (bclk_rise) begin
            ws_prev_d = ws_s;
        end
        case (cap_state_q)
            ST_IDLE: begin
                bit_cnt_d    = '0;
                shift_d      = '0;
                left_valid_d = 1'b0;
                if (Enable_i) begin
                    cap_state_d = ST_SYNC;
                end
            end
            ST_SYNC: begin
                bit_cnt_d    = '0;
                shift_d      = '0;
                left_valid_d = 1'b0;
                if (bclk_rise && ws_prev_q && !ws_s) begin
                    cap_state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bclk_rise) begin
                    if (ws_s != ws_prev_q) begin
                        if (!ws_prev_q) begin
                            left_hold_d  = placed;
                            left_valid_d = 1'b1;
                        end else if (left_valid_q) begin
                            push         = 1'b1;
                            push_word    = {left_hold_q, placed};
                            left_valid_d = 1'b0;
                        end
                        shift_d   = '0;
                        bit_cnt_d = '0;
                    end else begin
                        shift_d = placed;
                        if (bit_cnt_q < CNT_W'(DATA_WIDTH)) begin
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end
                end
            end
            default: cap_state_d = ST_IDLE;
        endcase
        if (!Enable_i) begin
            cap_state_d = ST_IDLE;
            push        = 1'b0;
        end
    end

    always_ff @(posedge WB_CLK or negedge WB_RST_n) begin
        if (!WB_RST_n) begin
            cap_state_q  <= ST_IDLE;
            ws_prev_q    <= 1'b0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            left_hold_q  <= '0;
            left_valid_q <= 1'b0;
        end else begin
            cap_state_q  <= cap_state_d;
            ws_prev_q    <= ws_prev_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            left_hold_q  <= left_hold_d;
            left_valid_q <= left_valid_d;
        end
    end

    assign flush = !Enable_i || (cap_state_q == ST_IDLE);
    assign full  = (level_q == LVL_W'(FIFO_DEPTH));
    assign empty = (level_q == '0);

    // A push into a full FIFO still succeeds when the head is popped in the same cycle.
    always_comb begin
        do_pop    = Rd_En_i && !empty && !flush;
        do_push   = push && !flush && (!full || do_pop);
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        overrun_d = overrun_q;
        if (Intr_Clr_i) begin
            overrun_d = 1'b0;
        end
        if (push && !flush && full && !do_pop) begin
            overrun_d = 1'b1;
        end
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
            level_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                level_d = level_q + LVL_W'(1);
            end else if (do_pop && !do_push) begin
                level_d = level_q - LVL_W'(1);
            end
        end
    end

    always_ff @(posedge WB_CLK or negedge WB_RST_n) begin
        if (!WB_RST_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= push_word;
        end
    end

    always_ff @(posedge WB_CLK or negedge WB_RST_n) begin
        if (!WB_RST_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        dma_state_d = dma_state_q;
        dma_intr_d  = 1'b0;
        case (dma_state_q)
            D_IDLE: if (level_q >= LVL_W'(DMA_THRESH)) dma_state_d = D_REQ;
            D_REQ:  if (SDMA_Active_i) dma_state_d = D_ACT;
            D_ACT: begin
                if (SDMA_Done_i) begin
                    dma_state_d = D_IDLE;
                    dma_intr_d  = 1'b1;
                end
            end
            default: dma_state_d = D_IDLE;
        endcase
        if (!Enable_i) begin
            dma_state_d = D_IDLE;
            dma_intr_d  = 1'b0;
        end
    end

    always_ff @(posedge WB_CLK or negedge WB_RST_n) begin
        if (!WB_RST_n) begin
            dma_state_q <= D_IDLE;
            dma_intr_q  <= 1'b0;
        end else begin
            dma_state_q <= dma_state_d;
            dma_intr_q  <= dma_intr_d;
        end
    end

    assign Rd_Data_o      = mem_q[rd_ptr_q];
    assign Fifo_Empty_o   = empty;
    assign Fifo_Level_o   = level_q;
    assign SDMA_Req_o     = (dma_state_q == D_REQ) && Enable_i;
    assign DMA_Intr_o     = dma_intr_q;
    assign Overrun_Intr_o = overrun_q;

endmodule

// File: tb/tb_i2s_slave_rx_capture.sv
// Directed bench for i2s_slave_rx_capture: drives a standard-I2S stream at WB_CLK/8
// and checks captured frames, FIFO, overrun and SDMA handshake against hand-computed values.
module tb_i2s_slave_rx_capture;

    logic        clk;
    logic        rstN;
    logic        bclk;
    logic        ws;
    logic        din;
    logic        enable;
    logic        intrClr;
    logic        rdEn;
    logic [31:0] rdData;
    logic        fifoEmpty;
    logic [2:0]  fifoLevel;
    logic        sdmaReq;
    logic        sdmaActive;
    logic        sdmaDone;
    logic        dmaIntr;
    logic        overrunIntr;

    int          vectors = 0;
    int          miscompares = 0;
    logic        pendingDin;
    logic        tailSent;

    i2s_slave_rx_capture #(
        .DATA_WIDTH(16),
        .FIFO_DEPTH(4),
        .DMA_THRESH(2)
    ) dut (
        .WB_CLK        (clk),
        .WB_RST_n      (rstN),
        .I2S_CLK_i     (bclk),
        .I2S_WS_CLK_i  (ws),
        .I2S_DIN_i     (din),
        .Enable_i      (enable),
        .Intr_Clr_i    (intrClr),
        .Rd_En_i       (rdEn),
        .Rd_Data_o     (rdData),
        .Fifo_Empty_o  (fifoEmpty),
        .Fifo_Level_o  (fifoLevel),
        .SDMA_Req_o    (sdmaReq),
        .SDMA_Active_i (sdmaActive),
        .SDMA_Done_i   (sdmaDone),
        .DMA_Intr_o    (dmaIntr),
        .Overrun_Intr_o(overrunIntr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One BCLK period (8 WB_CLK cycles); data changes while BCLK is low.
    task automatic sendBit(input logic w, input logic d);
        bclk = 1'b0;
        ws   = w;
        din  = d;
        #40;
        bclk = 1'b1;
        #40;
    endtask

    // DIN lags WS by one bit: each bit sent is the previous data bit.
    task automatic sendSlot(input logic w, input logic [31:0] word, input int slot,
                            input int from, input int upto);
        for (int i = from; i < upto; i++) begin
            if (!(tailSent && i == 0)) sendBit(w, pendingDin);
            tailSent   = 1'b0;
            pendingDin = word[slot-1-i];
        end
    endtask

    task automatic sendFrame(input logic [31:0] l, input logic [31:0] r, input int slot);
        sendSlot(1'b0, l, slot, 0, slot);
        sendSlot(1'b1, r, slot, 0, slot);
    endtask

    task automatic streamStart();
        tailSent   = 1'b0;
        pendingDin = 1'b0;
        sendSlot(1'b1, 32'h0, 16, 0, 16);
    endtask

    // First bit of the next left slot: carries the right LSB and completes the frame.
    task automatic sendTail(input logic popWithPush);
        bclk = 1'b0;
        ws   = 1'b0;
        din  = pendingDin;
        #40;
        bclk = 1'b1;
        if (popWithPush) begin
            #20 rdEn = 1'b1;
            #10 rdEn = 1'b0;
            #10;
        end else begin
            #40;
        end
        tailSent = 1'b1;
    endtask

    task automatic enableFresh();
        enable     = 1'b0;
        sdmaActive = 1'b0;
        repeat (3) @(negedge clk);
        intrClr = 1'b1;
        @(negedge clk);
        intrClr = 1'b0;
        enable  = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic popOne();
        rdEn = 1'b1;
        @(negedge clk);
        rdEn = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1 rstN = 1'b0;
        repeat (3) @(negedge clk);
        vectors++; if (fifoLevel !== 3'd0) begin miscompares++; $display("[TB] FAIL rst_level got %0d expected 0", fifoLevel); end
        vectors++; if (fifoEmpty !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_empty got %b expected 1", fifoEmpty); end
        vectors++; if (rdData !== 32'h0) begin miscompares++; $display("[TB] FAIL rst_data got %h expected 0", rdData); end
        vectors++; if (sdmaReq !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_req got %b expected 0", sdmaReq); end
        vectors++; if (dmaIntr !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_dmaintr got %b expected 0", dmaIntr); end
        vectors++; if (overrunIntr !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_overrun got %b expected 0", overrunIntr); end
        rstN = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_frame();
        enableFresh();
        streamStart();
        sendFrame(32'hA5C3, 32'h1234, 16);
        sendTail(1'b0);
        @(negedge clk);
        vectors++; if (fifoLevel !== 3'd1) begin miscompares++; $display("[TB] FAIL basic_level got %0d expected 1", fifoLevel); end
        vectors++; if (fifoEmpty !== 1'b0) begin miscompares++; $display("[TB] FAIL basic_empty got %b expected 0", fifoEmpty); end
        vectors++; if (rdData !== 32'hA5C31234) begin miscompares++; $display("[TB] FAIL basic_data got %h expected a5c31234", rdData); end
    endtask

    task automatic test_word_length();
        enableFresh();
        streamStart();
        sendFrame(32'hDEADBEEF, 32'h0F0F1111, 32);
        sendTail(1'b0);
        @(negedge clk);
        vectors++; if (rdData !== 32'hDEAD0F0F) begin miscompares++; $display("[TB] FAIL trunc_data got %h expected dead0f0f", rdData); end
        sendFrame(32'hABC, 32'h123, 12);
        sendTail(1'b0);
        @(negedge clk);
        vectors++; if (fifoLevel !== 3'd2) begin miscompares++; $display("[TB] FAIL short_level got %0d expected 2", fifoLevel); end
        popOne();
        vectors++; if (rdData !== 32'hABC01230) begin miscompares++; $display("[TB] FAIL short_data got %h expected abc01230", rdData); end
    endtask

    task automatic test_overrun();
        logic [31:0] expected;
        enableFresh();
        streamStart();
        for (int i = 0; i < 5; i++) begin
            sendFrame(32'h1000 + i, 32'h2000 + i, 16);
            sendTail(1'b0);
        end
        @(negedge clk);
        vectors++; if (fifoLevel !== 3'd4) begin miscompares++; $display("[TB] FAIL ovr_level got %0d expected 4", fifoLevel); end
        vectors++; if (overrunIntr !== 1'b1) begin miscompares++; $display("[TB] FAIL ovr_flag got %b expected 1", overrunIntr); end
        for (int i = 0; i < 4; i++) begin
            expected = {16'h1000 + 16'(i), 16'h2000 + 16'(i)};
            vectors++; if (rdData !== expected) begin miscompares++; $display("[TB] FAIL ovr_pop%0d got %h expected %h", i, rdData, expected); end
            popOne();
        end
        vectors++; if (fifoEmpty !== 1'b1) begin miscompares++; $display("[TB] FAIL ovr_empty got %b expected 1", fifoEmpty); end
        vectors++; if (overrunIntr !== 1'b1) begin miscompares++; $display("[TB] FAIL ovr_sticky got %b expected 1", overrunIntr); end
        intrClr = 1'b1;
        @(negedge clk);
        intrClr = 1'b0;
        vectors++; if (overrunIntr !== 1'b0) begin miscompares++; $display("[TB] FAIL ovr_clear got %b expected 0", overrunIntr); end
    endtask

    task automatic test_dma();
        enableFresh();
        streamStart();
        sendFrame(32'h0101, 32'h0202, 16);
        sendTail(1'b0);
        repeat (3) @(negedge clk);
        vectors++; if (sdmaReq !== 1'b0) begin miscompares++; $display("[TB] FAIL dma_req_lvl1 got %b expected 0", sdmaReq); end
        sendFrame(32'h0303, 32'h0404, 16);
        sendTail(1'b0);
        repeat (2) @(negedge clk);
        vectors++; if (sdmaReq !== 1'b1) begin miscompares++; $display("[TB] FAIL dma_req_lvl2 got %b expected 1", sdmaReq); end
        sdmaActive = 1'b1;
        @(negedge clk);
        vectors++; if (sdmaReq !== 1'b0) begin miscompares++; $display("[TB] FAIL dma_req_active got %b expected 0", sdmaReq); end
        popOne();
        popOne();
        sdmaDone = 1'b1;
        @(negedge clk);
        sdmaDone = 1'b0;
        vectors++; if (dmaIntr !== 1'b1) begin miscompares++; $display("[TB] FAIL dma_intr_pulse got %b expected 1", dmaIntr); end
        @(negedge clk);
        vectors++; if (dmaIntr !== 1'b0) begin miscompares++; $display("[TB] FAIL dma_intr_single got %b expected 0", dmaIntr); end
        sdmaActive = 1'b0;
        repeat (3) @(negedge clk);
        vectors++; if (sdmaReq !== 1'b0) begin miscompares++; $display("[TB] FAIL dma_idle_req got %b expected 0", sdmaReq); end
        sdmaDone = 1'b1;
        @(negedge clk);
        sdmaDone = 1'b0;
        vectors++; if (dmaIntr !== 1'b0) begin miscompares++; $display("[TB] FAIL dma_done_ignored got %b expected 0", dmaIntr); end
    endtask

    task automatic test_disable();
        enableFresh();
        streamStart();
        for (int i = 0; i < 3; i++) begin
            sendFrame(32'h7000 + i, 32'h8000 + i, 16);
            sendTail(1'b0);
        end
        repeat (2) @(negedge clk);
        vectors++; if (fifoLevel !== 3'd3) begin miscompares++; $display("[TB] FAIL dis_level3 got %0d expected 3", fifoLevel); end
        vectors++; if (sdmaReq !== 1'b1) begin miscompares++; $display("[TB] FAIL dis_req_before got %b expected 1", sdmaReq); end
        sendSlot(1'b0, 32'h7777, 16, 0, 16);
        sendSlot(1'b1, 32'h8888, 16, 0, 8);
        enable = 1'b0;
        repeat (3) @(negedge clk);
        vectors++; if (fifoLevel !== 3'd0) begin miscompares++; $display("[TB] FAIL dis_flush got %0d expected 0", fifoLevel); end
        vectors++; if (sdmaReq !== 1'b0) begin miscompares++; $display("[TB] FAIL dis_req got %b expected 0", sdmaReq); end
        enable = 1'b1;
        repeat (2) @(negedge clk);
        sendSlot(1'b1, 32'h8888, 16, 8, 16);
        sendFrame(32'h5555, 32'h6666, 16);
        vectors++; if (fifoLevel !== 3'd0) begin miscompares++; $display("[TB] FAIL dis_resync_level got %0d expected 0", fifoLevel); end
        sendTail(1'b0);
        @(negedge clk);
        vectors++; if (fifoLevel !== 3'd1) begin miscompares++; $display("[TB] FAIL dis_after_level got %0d expected 1", fifoLevel); end
        vectors++; if (rdData !== 32'h55556666) begin miscompares++; $display("[TB] FAIL dis_after_data got %h expected 55556666", rdData); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] expected;
        enableFresh();
        streamStart();
        for (int i = 0; i < 4; i++) begin
            sendFrame(32'h3000 + i, 32'h4000 + i, 16);
            sendTail(1'b0);
        end
        @(negedge clk);
        vectors++; if (fifoLevel !== 3'd4) begin miscompares++; $display("[TB] FAIL b2b_full got %0d expected 4", fifoLevel); end
        sendFrame(32'h3004, 32'h4004, 16);
        sendTail(1'b1);
        @(negedge clk);
        vectors++; if (fifoLevel !== 3'd4) begin miscompares++; $display("[TB] FAIL b2b_level got %0d expected 4", fifoLevel); end
        vectors++; if (overrunIntr !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_overrun got %b expected 0", overrunIntr); end
        for (int i = 1; i < 5; i++) begin
            expected = {16'h3000 + 16'(i), 16'h4000 + 16'(i)};
            vectors++; if (rdData !== expected) begin miscompares++; $display("[TB] FAIL b2b_pop%0d got %h expected %h", i, rdData, expected); end
            popOne();
        end
    endtask

    task automatic test_async_reset();
        enableFresh();
        streamStart();
        sendFrame(32'hC0DE, 32'hBEEF, 16);
        sendTail(1'b0);
        sendSlot(1'b0, 32'h1357, 16, 0, 5);
        #3 rstN = 1'b0;
        #1;
        vectors++; if (fifoLevel !== 3'd0) begin miscompares++; $display("[TB] FAIL arst_level got %0d expected 0", fifoLevel); end
        vectors++; if (fifoEmpty !== 1'b1) begin miscompares++; $display("[TB] FAIL arst_empty got %b expected 1", fifoEmpty); end
        vectors++; if (rdData !== 32'h0) begin miscompares++; $display("[TB] FAIL arst_data got %h expected 0", rdData); end
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rstN       = 1'b1;
        bclk       = 1'b0;
        ws         = 1'b0;
        din        = 1'b0;
        enable     = 1'b0;
        intrClr    = 1'b0;
        rdEn       = 1'b0;
        sdmaActive = 1'b0;
        sdmaDone   = 1'b0;
        pendingDin = 1'b0;
        tailSent   = 1'b0;
        test_reset();
        test_basic_frame();
        test_word_length();
        test_overrun();
        test_dma();
        test_disable();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
